// File: rtl/vrf_wb_scheduler.sv
// Vector register file write-port scheduler with pending-write scoreboard.
// Round-robin merges ALU and load writeback beats onto one registered VRF port.
module vrf_wb_scheduler #(
   parameter int NUM_REGS = 8,
   parameter int REG_W    = 64,
   parameter int ELEM_W   = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NBE      = REG_W / ELEM_W
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [ADDR_W-1:0]     issue_vd,
   input  logic [3*ADDR_W-1:0]   issue_vs,
   input  logic [2:0]            issue_vs_used,
   input  logic                  issue_vd_used,
   input  logic [1:0]            wr_valid,
   output logic [1:0]            wr_ready,
   input  logic [2*ADDR_W-1:0]   wr_addr,
   input  logic [2*NBE-1:0]      wr_be,
   input  logic [2*REG_W-1:0]    wr_data,
   input  logic [1:0]            wr_last,
   output logic [ADDR_W-1:0]     vrf_wr_addr,
   output logic [NBE-1:0]        vrf_wr_en,
   output logic [REG_W-1:0]      vrf_wr_data,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  err_unpending
);

   localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);
   localparam logic [NUM_REGS-1:0] KEEP = ~ONE;

   logic [NUM_REGS-1:0] r_pending;
   logic                r_rr;
   logic [ADDR_W-1:0]   r_addr;
   logic [NBE-1:0]      r_en;
   logic [REG_W-1:0]    r_data;
   logic                r_err;

   logic [1:0]          w_grant;
   logic                w_accept;
   logic                w_gsel;
   logic [ADDR_W-1:0]   w_addr;
   logic [NBE-1:0]      w_be;
   logic [REG_W-1:0]    w_data;
   logic                w_last;
   logic                w_hazard;
   logic                w_issue_fire;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   logic [NUM_REGS-1:0] w_pend_nxt;
   logic                w_err_hit;

   // Hazard check reads registered pending only: no same-cycle clear bypass.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (issue_vs_used[i] && r_pending[issue_vs[i*ADDR_W +: ADDR_W]])
            w_hazard = 1'b1;
      end
      if (issue_vd_used && r_pending[issue_vd])
         w_hazard = 1'b1;
   end

   assign issue_ready  = ~w_hazard;
   assign w_issue_fire = issue_valid & ~w_hazard;

   always_comb begin
      w_grant = 2'b00;
      unique case (wr_valid)
         2'b11:   w_grant[r_rr] = 1'b1;
         default: w_grant = wr_valid;
      endcase
   end

   assign wr_ready = w_grant;
   assign w_accept = |w_grant;
   assign w_gsel   = w_grant[1];
   assign w_addr   = w_gsel ? wr_addr[ADDR_W +: ADDR_W] : wr_addr[0 +: ADDR_W];
   assign w_be     = w_gsel ? wr_be[NBE +: NBE] : wr_be[0 +: NBE];
   assign w_data   = w_gsel ? wr_data[REG_W +: REG_W] : wr_data[0 +: REG_W];
   assign w_last   = w_gsel ? wr_last[1] : wr_last[0];

   assign w_set = (w_issue_fire && issue_vd_used) ? (ONE << issue_vd) : '0;
   assign w_clr = (w_accept && w_last) ? (ONE << w_addr) : '0;

   // Set is applied after clear so a colliding set wins; v0 never pends.
   assign w_pend_nxt = ((r_pending & ~w_clr) | w_set) & KEEP;

   assign w_err_hit = w_accept & w_last & (w_addr != '0) & ~r_pending[w_addr];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_pending <= '0;
         r_rr      <= 1'b0;
         r_addr    <= '0;
         r_en      <= '0;
         r_data    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_accept) begin
            r_rr   <= ~w_gsel;
            r_addr <= w_addr;
            r_data <= w_data;
            r_en   <= (w_addr == '0) ? '0 : w_be;
         end else begin
            r_en   <= '0;
         end
         if (w_err_hit)
            r_err <= 1'b1;
      end
   end

   assign vrf_wr_addr   = r_addr;
   assign vrf_wr_en     = r_en;
   assign vrf_wr_data   = r_data;
   assign pending       = r_pending;
   assign err_unpending = r_err;

endmodule

// File: tb/tb_vrf_wb_scheduler.sv
// Scoreboard bench for vrf_wb_scheduler: model predicts handshakes and
// queues expected VRF-port state; a monitor pops one entry per cycle.
module tb_vrf_wb_scheduler;

   logic        clk = 1'b0;
   logic        nreset;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  issue_vd;
   logic [8:0]  issue_vs;
   logic [2:0]  issue_vs_used;
   logic        issue_vd_used;
   logic [1:0]  wr_valid;
   logic [1:0]  wr_ready;
   logic [5:0]  wr_addr;
   logic [15:0] wr_be;
   logic [127:0] wr_data;
   logic [1:0]  wr_last;
   logic [2:0]  vrf_wr_addr;
   logic [7:0]  vrf_wr_en;
   logic [63:0] vrf_wr_data;
   logic [7:0]  pending;
   logic        err_unpending;

   vrf_wb_scheduler dut (
      .clk(clk), .nreset(nreset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_vd(issue_vd), .issue_vs(issue_vs),
      .issue_vs_used(issue_vs_used), .issue_vd_used(issue_vd_used),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_be(wr_be), .wr_data(wr_data), .wr_last(wr_last),
      .vrf_wr_addr(vrf_wr_addr), .vrf_wr_en(vrf_wr_en),
      .vrf_wr_data(vrf_wr_data), .pending(pending),
      .err_unpending(err_unpending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  addr;
      logic [7:0]  en;
      logic [63:0] data;
      logic [7:0]  pend;
      logic        err;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   bit [7:0]  m_pend;
   bit        m_pref;
   bit        m_err;
   bit [2:0]  m_addr;
   bit [63:0] m_data;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_pref = 0; m_err = 0; m_addr = 0; m_data = 0;
      q.delete();
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_vd = 0; issue_vs = 0;
      issue_vs_used = 0; issue_vd_used = 0;
      wr_valid = 0; wr_addr = 0; wr_be = 0; wr_data = 0; wr_last = 0;
   endtask

   // Inputs are already applied just after a negedge; predict and queue.
   task automatic step();
      bit        hz;
      bit [1:0]  g;
      int        c;
      bit [2:0]  a;
      bit [7:0]  np;
      bit [7:0]  en;
      #1;
      hz = 0;
      for (int i = 0; i < 3; i++)
         if (issue_vs_used[i] && m_pend[issue_vs[i*3 +: 3]]) hz = 1;
      if (issue_vd_used && m_pend[issue_vd]) hz = 1;
      chk("issue_ready", issue_ready, !hz);
      if (wr_valid == 2'b11) g = m_pref ? 2'b10 : 2'b01;
      else g = wr_valid;
      chk("wr_ready", wr_ready, g);
      np = m_pend;
      en = 0;
      if (g != 0) begin
         c = g[1] ? 1 : 0;
         a = wr_addr[c*3 +: 3];
         if (wr_last[c]) begin
            if (a != 0 && !m_pend[a]) m_err = 1;
            np[a] = 0;
         end
         en = (a == 0) ? 8'h00 : wr_be[c*8 +: 8];
         m_addr = a;
         m_data = wr_data[c*64 +: 64];
         m_pref = (c == 0);
      end
      if (issue_valid && !hz && issue_vd_used && issue_vd != 0)
         np[issue_vd] = 1;
      np[0] = 0;
      m_pend = np;
      q.push_back('{m_addr, en, m_data, m_pend, m_err});
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (nreset && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("vrf_wr_addr", vrf_wr_addr, e.addr);
         chk("vrf_wr_en", vrf_wr_en, e.en);
         chk("vrf_wr_data", vrf_wr_data, e.data);
         chk("pending", pending, e.pend);
         chk("err_unpending", err_unpending, e.err);
      end
   end

   task automatic issue(bit [2:0] vd, bit vdu, bit [8:0] vs, bit [2:0] vsu);
      issue_valid = 1; issue_vd = vd; issue_vd_used = vdu;
      issue_vs = vs; issue_vs_used = vsu;
   endtask

   task automatic beat(int c, bit [2:0] a, bit [7:0] be, bit [63:0] d, bit l);
      wr_valid[c] = 1; wr_addr[c*3 +: 3] = a; wr_be[c*8 +: 8] = be;
      wr_data[c*64 +: 64] = d; wr_last[c] = l;
   endtask

   task automatic check_zero_outputs(string tag);
      chk({tag, "_addr"}, vrf_wr_addr, 0);
      chk({tag, "_en"}, vrf_wr_en, 0);
      chk({tag, "_data"}, vrf_wr_data, 0);
      chk({tag, "_pending"}, pending, 0);
      chk({tag, "_err"}, err_unpending, 0);
   endtask

   initial begin
      idle_inputs();
      model_reset();
      nreset = 0;
      #2;
      check_zero_outputs("reset");
      issue_valid = 1;
      #1;
      chk("reset_issue_ready", issue_ready, 1);
      chk("reset_wr_ready", wr_ready, 0);
      @(negedge clk);
      @(negedge clk);
      nreset = 1;
      idle_inputs();

      // dual contention from reset: 01,10,01,10
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         beat(0, 3'd1, 8'h0F, 64'h1111 + i, 0);
         beat(1, 3'd2, 8'hF0, 64'h2222 + i, 0);
         step();
      end

      // RAW hazard and clear
      idle_inputs();
      issue(3'd3, 1, {3'd0, 3'd2, 3'd1}, 3'b011);
      step();
      idle_inputs();
      issue(3'd0, 0, {3'd0, 3'd0, 3'd3}, 3'b001);
      step();
      beat(0, 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678, 1);
      step();
      idle_inputs();
      issue(3'd0, 0, {3'd0, 3'd0, 3'd3}, 3'b001);
      step();

      // channel 1 beat to v0
      idle_inputs();
      beat(1, 3'd0, 8'hFF, 64'hDEAD, 0);
      step();

      // vd=0 issue, unused source on pending reg
      idle_inputs();
      issue(3'd0, 1, 9'd0, 3'b000);
      step();
      issue(3'd5, 1, 9'd0, 3'b000);
      step();
      issue(3'd6, 1, {3'd5, 3'd5, 3'd5}, 3'b000);
      step();
      idle_inputs();
      beat(1, 3'd5, 8'h3C, 64'h55, 1);
      step();
      beat(0, 3'd6, 8'h01, 64'h66, 1);
      step();

      // unpending last beat sets sticky error
      idle_inputs();
      beat(1, 3'd5, 8'hFF, 64'h77, 1);
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         beat(i % 2, 3'(i + 1), 8'hAA, 64'(i), 0);
         step();
         idle_inputs();
      end

      // reset mid-beat
      issue(3'd4, 1, 9'd0, 3'b000);
      step();
      beat(0, 3'd4, 8'hFF, 64'h99, 1);
      beat(1, 3'd2, 8'hFF, 64'h98, 0);
      #2;
      nreset = 0;
      #1;
      check_zero_outputs("midreset");
      model_reset();
      @(negedge clk);
      nreset = 1;
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle_inputs();
         issue_valid   = 1'($urandom);
         issue_vd      = 3'($urandom);
         issue_vd_used = 1'($urandom);
         issue_vs      = 9'($urandom);
         issue_vs_used = 3'($urandom);
         wr_valid      = 2'($urandom);
         wr_addr       = 6'($urandom);
         wr_be         = 16'($urandom);
         wr_data       = {$urandom, $urandom, $urandom, $urandom};
         wr_last       = 2'($urandom);
         step();
      end

      idle_inputs();
      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
